// File: rtl/hbridge_pwm_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hbridge_pkg                                             |
// | Purpose  : Shared types and reset constants for the full-bridge    |
// |            PWM generator (leg FSM states, period phase, defaults). |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package hbridge_pkg;

  // Per-leg gate state: exactly one side driven, or neither while dead.
  typedef enum logic [1:0] {
    LEG_LOW_ON  = 2'd0,
    LEG_DEAD    = 2'd1,
    LEG_HIGH_ON = 2'd2
  } leg_state_t;

  // Which half of the switching period the counter is in.
  typedef enum logic {
    HALF0 = 1'b0,
    HALF1 = 1'b1
  } phase_t;

  // Configuration loaded at reset.
  localparam int unsigned c_def_period = 100;
  localparam int unsigned c_def_width  = 40;
  localparam int unsigned c_def_dead   = 4;

  // Shortest period the shadow logic will accept.
  localparam int unsigned c_min_period = 4;

endpackage
`default_nettype wire

// File: rtl/hbridge_pwm_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hbridge_pwm_gen_if                                      |
// | Purpose  : Configuration handshake bundle (valid/ready plus        |
// |            period, width, dead time and reject pulse).             |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface hbridge_pwm_gen_if #(
  parameter int CNT_W = 16,
  parameter int DT_W  = 6
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic [DT_W-1:0]  cfg_dead;
  logic             cfg_err;

  // Control logic side: offers configurations.
  modport master (
    output cfg_valid, cfg_period, cfg_width, cfg_dead,
    input  cfg_ready, cfg_err
  );

  // PWM generator side: accepts or rejects configurations.
  modport slave (
    input  cfg_valid, cfg_period, cfg_width, cfg_dead,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/hbridge_pwm_gen_deadtime_leg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : deadtime_leg                                            |
// | Purpose  : One bridge leg. Turns the ideal level into high/low     |
// |            gate drives with dead time inserted on every edge.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module deadtime_leg
  import hbridge_pkg::*;
#(
  parameter int DT_W = 6
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_ideal,
  input  wire logic [DT_W-1:0] i_dead,
  output logic                 o_hs,
  output logic                 o_ls
);

  localparam logic [DT_W-1:0] c_one = DT_W'(1);

  leg_state_t      r_state;
  logic [DT_W-1:0] r_dcnt;
  logic            r_hs;
  logic            r_ls;

  // Leg FSM with registered gate outputs; both sides are released
  // before the other side is allowed on, so hs and ls never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LEG_LOW_ON;
      r_dcnt  <= '0;
      r_hs    <= 1'b0;
      r_ls    <= 1'b1;
    end else begin
      case (r_state)
        LEG_LOW_ON: begin
          if (i_ideal) begin
            r_ls <= 1'b0;
            if (i_dead == '0) begin
              r_state <= LEG_HIGH_ON;
              r_hs    <= 1'b1;
            end else begin
              r_state <= LEG_DEAD;
              r_dcnt  <= i_dead;
            end
          end
        end
        LEG_HIGH_ON: begin
          if (!i_ideal) begin
            r_hs <= 1'b0;
            if (i_dead == '0) begin
              r_state <= LEG_LOW_ON;
              r_ls    <= 1'b1;
            end else begin
              r_state <= LEG_DEAD;
              r_dcnt  <= i_dead;
            end
          end
        end
        LEG_DEAD: begin
          // The dead counter is never restarted by ideal glitches; on
          // expiry whichever side the ideal currently asks for turns on.
          if (r_dcnt <= c_one) begin
            r_dcnt <= '0;
            if (i_ideal) begin
              r_state <= LEG_HIGH_ON;
              r_hs    <= 1'b1;
            end else begin
              r_state <= LEG_LOW_ON;
              r_ls    <= 1'b1;
            end
          end else begin
            r_dcnt <= r_dcnt - c_one;
          end
        end
        default: begin
          r_state <= LEG_LOW_ON;
          r_dcnt  <= '0;
          r_hs    <= 1'b0;
          r_ls    <= 1'b1;
        end
      endcase
    end
  end

  assign o_hs = r_hs;
  assign o_ls = r_ls;

endmodule
`default_nettype wire

// File: rtl/hbridge_pwm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hbridge_pwm_gen                                         |
// | Purpose  : Full-bridge PWM driver. Shadows configuration, runs the |
// |            two-half period counter and feeds two dead-time legs.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module hbridge_pwm_gen
  import hbridge_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DT_W       = 6,
  parameter int MIN_PERIOD = int'(c_min_period)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        en,
  input  wire logic        mode,
  hbridge_pwm_gen_if.slave cfg,
  output logic             hs_a,
  output logic             ls_a,
  output logic             hs_b,
  output logic             ls_b,
  output logic             cycle_start
);

  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_min_per = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] c_rst_per = CNT_W'(c_def_period);
  localparam logic [CNT_W-1:0] c_rst_wid = CNT_W'(c_def_width);
  localparam logic [DT_W-1:0]  c_rst_dt  = DT_W'(c_def_dead);

  // Active configuration, only ever updated at a period boundary or
  // while disabled.
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_wid;
  logic [DT_W-1:0]  r_dead;

  // Pending (shadow) configuration.
  logic [CNT_W-1:0] r_pnd_per;
  logic [CNT_W-1:0] r_pnd_wid;
  logic [DT_W-1:0]  r_pnd_dead;
  logic             r_pnd_full;
  logic             r_err;

  // Period timing.
  logic [CNT_W-1:0] r_cnt;
  phase_t           r_phase;
  logic             r_run;
  logic             r_cs;

  logic [CNT_W-1:0] w_h0;
  logic [CNT_W-1:0] w_h1;
  logic [CNT_W-1:0] w_off_h0;
  logic [CNT_W-1:0] w_cnt_nxt;
  phase_t           w_phase_nxt;
  logic             w_half_end;
  logic             w_period_end;
  logic             w_take;
  logic             w_cfg_ok;
  logic             w_xfer;
  logic             w_ideal_a;
  logic             w_ideal_b;

  // Half lengths, boundaries, handshake decode and next counter state.
  always_comb begin
    w_h0         = r_per >> 1;
    w_h1         = r_per - w_h0;
    w_half_end   = (r_phase == HALF0) ? (r_cnt >= w_h0 - c_one)
                                      : (r_cnt >= w_h1 - c_one);
    w_period_end = r_run && (r_phase == HALF1) && w_half_end;

    w_off_h0 = cfg.cfg_period >> 1;
    w_cfg_ok = (cfg.cfg_period >= c_min_per) && (cfg.cfg_width <= w_off_h0);
    w_take   = cfg.cfg_valid && !r_pnd_full;
    w_xfer   = r_pnd_full && (w_period_end || !en);

    // A first enabled cycle (r_run low) parks the counter at the start
    // of half0 so the first period after enable is complete.
    w_cnt_nxt   = '0;
    w_phase_nxt = HALF0;
    if (en && r_run) begin
      if (w_half_end) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = (r_phase == HALF0) ? HALF1 : HALF0;
      end else begin
        w_cnt_nxt   = r_cnt + c_one;
        w_phase_nxt = r_phase;
      end
    end

    w_ideal_a = en && r_run && (r_phase == HALF0) && (r_cnt < r_wid);
    w_ideal_b = en && r_run && !mode && (r_phase == HALF1) && (r_cnt < r_wid);
  end

  // Configuration shadowing: validate offers, hold one pending, and
  // promote it at the period boundary (or at once while disabled).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per      <= c_rst_per;
      r_wid      <= c_rst_wid;
      r_dead     <= c_rst_dt;
      r_pnd_per  <= '0;
      r_pnd_wid  <= '0;
      r_pnd_dead <= '0;
      r_pnd_full <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_take && !w_cfg_ok;
      if (w_xfer) begin
        r_per      <= r_pnd_per;
        r_wid      <= r_pnd_wid;
        r_dead     <= r_pnd_dead;
        r_pnd_full <= 1'b0;
      end else if (w_take && w_cfg_ok) begin
        r_pnd_per  <= cfg.cfg_period;
        r_pnd_wid  <= cfg.cfg_width;
        r_pnd_dead <= cfg.cfg_dead;
        r_pnd_full <= 1'b1;
      end
    end
  end

  // Period/phase counter and the registered start-of-period pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= HALF0;
      r_run   <= 1'b0;
      r_cs    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_run   <= en;
      r_cs    <= en && (w_cnt_nxt == '0) && (w_phase_nxt == HALF0);
    end
  end

  deadtime_leg #(.DT_W(DT_W)) u_leg_a (
    .clk     (clk),
    .rst     (rst),
    .i_ideal (w_ideal_a),
    .i_dead  (r_dead),
    .o_hs    (hs_a),
    .o_ls    (ls_a)
  );

  deadtime_leg #(.DT_W(DT_W)) u_leg_b (
    .clk     (clk),
    .rst     (rst),
    .i_ideal (w_ideal_b),
    .i_dead  (r_dead),
    .o_hs    (hs_b),
    .o_ls    (ls_b)
  );

  assign cfg.cfg_ready = !r_pnd_full;
  assign cfg.cfg_err   = r_err;
  assign cycle_start   = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_pwm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_hbridge_pwm_gen                                      |
// | Purpose  : Self-checking bench: cycle-level reference model with   |
// |            absolute-time dead-time tracking, directed sequences,   |
// |            a config vector table and randomized traffic.           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_hbridge_pwm_gen;
  import hbridge_pkg::*;

  localparam int CNT_W = 16;
  localparam int DT_W  = 6;
  localparam int SIDE_LOW  = 0;
  localparam int SIDE_HIGH = 1;
  localparam int SIDE_NONE = 2;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic mode;
  logic hs_a, ls_a, hs_b, ls_b, cycle_start;

  hbridge_pwm_gen_if #(.CNT_W(CNT_W), .DT_W(DT_W)) cfg_if ();

  hbridge_pwm_gen #(.CNT_W(CNT_W), .DT_W(DT_W), .MIN_PERIOD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .cfg         (cfg_if),
    .hs_a        (hs_a),
    .ls_a        (ls_a),
    .hs_b        (hs_b),
    .ls_b        (ls_b),
    .cycle_start (cycle_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle", name, act, exp);
    end
  endtask

  // Reference model: period position 0..P-1 and per-leg on-side with
  // the absolute cycle at which a dead interval ends.
  int     m_p, m_w, m_d;
  bit     m_pend;
  int     m_pp, m_pw, m_pd;
  int     m_pos;
  bit     m_run, m_cs, m_err;
  int     m_side [2];
  longint m_on_at [2];
  longint cyc = 0;

  task automatic model_reset();
    m_p = 100; m_w = 40; m_d = 4;
    m_pend = 0; m_pp = 0; m_pw = 0; m_pd = 0;
    m_pos = 0; m_run = 0; m_cs = 0; m_err = 0;
    for (int i = 0; i < 2; i++) begin
      m_side[i]  = SIDE_LOW;
      m_on_at[i] = 0;
    end
  endtask

  task automatic drive_cfg(int p, int w, int d);
    cfg_if.cfg_period = CNT_W'(p);
    cfg_if.cfg_width  = CNT_W'(w);
    cfg_if.cfg_dead   = DT_W'(d);
  endtask

  // One clock: predict from pre-edge inputs, advance, compare.
  task automatic tick();
    int h0, npos;
    bit idl [2];
    bit take, ok, xfer, nrun, ncs, nerr;
    h0 = m_p / 2;
    idl[0] = en && m_run && (m_pos < m_w);
    idl[1] = en && m_run && !mode && (m_pos >= h0) && (m_pos - h0 < m_w);
    for (int i = 0; i < 2; i++) begin
      if (m_side[i] != SIDE_NONE && m_side[i] != int'(idl[i])) begin
        if (m_d == 0) m_side[i] = int'(idl[i]);
        else begin
          m_side[i]  = SIDE_NONE;
          m_on_at[i] = cyc + 1 + m_d;
        end
      end else if (m_side[i] == SIDE_NONE && cyc + 1 == m_on_at[i]) begin
        m_side[i] = int'(idl[i]);
      end
    end
    take = cfg_if.cfg_valid && !m_pend;
    ok   = (cfg_if.cfg_period >= 4) && (cfg_if.cfg_width <= cfg_if.cfg_period / 2);
    nerr = take && !ok;
    xfer = m_pend && (!en || (m_run && m_pos == m_p - 1));
    if (!en) begin
      npos = 0; nrun = 0;
    end else if (!m_run) begin
      npos = 0; nrun = 1;
    end else begin
      npos = (m_pos == m_p - 1) ? 0 : m_pos + 1; nrun = 1;
    end
    ncs = en && (npos == 0);
    @(posedge clk);
    #1;
    cyc++;
    m_pos = npos; m_run = nrun; m_cs = ncs; m_err = nerr;
    if (xfer) begin
      m_p = m_pp; m_w = m_pw; m_d = m_pd; m_pend = 0;
    end
    if (take && ok) begin
      m_pend = 1;
      m_pp = int'(cfg_if.cfg_period);
      m_pw = int'(cfg_if.cfg_width);
      m_pd = int'(cfg_if.cfg_dead);
    end
    check("hs_a", hs_a, m_side[0] == SIDE_HIGH);
    check("ls_a", ls_a, m_side[0] == SIDE_LOW);
    check("hs_b", hs_b, m_side[1] == SIDE_HIGH);
    check("ls_b", ls_b, m_side[1] == SIDE_LOW);
    check("cycle_start", cycle_start, m_cs);
    check("cfg_err", cfg_if.cfg_err, m_err);
    check("cfg_ready", cfg_if.cfg_ready, !m_pend);
    check("overlap_a", hs_a & ls_a, 0);
    check("overlap_b", hs_b & ls_b, 0);
  endtask

  // Asynchronous reset assertion between clock edges.
  task automatic async_reset(string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_hs_a"}, hs_a, 0);
    check({tag, "_ls_a"}, ls_a, 1);
    check({tag, "_hs_b"}, hs_b, 0);
    check({tag, "_ls_b"}, ls_b, 1);
    check({tag, "_cs"}, cycle_start, 0);
    check({tag, "_ready"}, cfg_if.cfg_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_cs(int bound, string name);
    int n = 0;
    while (cycle_start !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(name, cycle_start, 1);
  endtask

  task automatic offer(int p, int w, int d);
    drive_cfg(p, w, d);
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  typedef struct {
    int p;
    int w;
    int d;
    bit exp_err;
    bit exp_ready;
  } cfg_vec_t;

  cfg_vec_t vecs [9];

  initial begin
    longint t0;
    int na, nb, ra, rb, la, lsr, nlsb, n;

    vecs[0] = '{3,     1,     0,  1, 1};
    vecs[1] = '{20,    11,    0,  1, 1};
    vecs[2] = '{0,     0,     0,  1, 1};
    vecs[3] = '{65535, 32768, 0,  1, 1};
    vecs[4] = '{2,     1,     0,  1, 1};
    vecs[5] = '{21,    10,    5,  0, 0};
    vecs[6] = '{4,     2,     0,  0, 0};
    vecs[7] = '{9,     0,     3,  0, 0};
    vecs[8] = '{20,    10,    0,  0, 0};

    rst = 1'b1; en = 1'b0; mode = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    drive_cfg(0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("reset_hs_a", hs_a, 0);
    check("reset_ls_a", ls_a, 1);
    check("reset_hs_b", hs_b, 0);
    check("reset_ls_b", ls_b, 1);
    check("reset_cs", cycle_start, 0);
    check("reset_err", cfg_if.cfg_err, 0);
    check("reset_ready", cfg_if.cfg_ready, 1);

    // Default pattern P=100 W=40 D=4.
    en = 1'b1;
    wait_cs(10, "first_cs");
    na = 0; nb = 0; ra = -1; rb = -1; la = -1; lsr = -1;
    for (int k = 0; k < 100; k++) begin
      if (hs_a) begin na++; if (ra < 0) ra = k; la = k; end
      if (hs_b) begin nb++; if (rb < 0) rb = k; end
      if (la >= 0 && !hs_a && ls_a && lsr < 0) lsr = k;
      tick();
    end
    check("def_period_100", cycle_start, 1);
    check("def_hs_a_start", ra, 5);
    check("def_hs_a_len", na, 36);
    check("def_ls_a_return", lsr - la, 5);
    check("def_hs_b_start", rb, 55);
    check("def_hs_b_len", nb, 36);

    // Async reset while leg A is in HIGH_ON.
    repeat (10) tick();
    check("pre_rst_high", hs_a, 1);
    async_reset("rst_high");

    // Mid-period reconfiguration to P=20 W=6 D=2.
    wait_cs(10, "cs_after_rst");
    t0 = cyc;
    repeat (30) tick();
    offer(20, 6, 2);
    check("reconf_ready_low", cfg_if.cfg_ready, 0);
    wait_cs(200, "reconf_cs");
    check("reconf_old_period", int'(cyc - t0), 100);
    check("reconf_ready_back", cfg_if.cfg_ready, 1);
    na = 0;
    for (int k = 0; k < 20; k++) begin
      if (hs_a) na++;
      tick();
    end
    check("reconf_period_20", cycle_start, 1);
    check("reconf_hs_len", na, 4);

    // Config acceptance table.
    for (int i = 0; i < 9; i++) begin
      offer(vecs[i].p, vecs[i].w, vecs[i].d);
      check("vec_err", cfg_if.cfg_err, vecs[i].exp_err);
      check("vec_ready", cfg_if.cfg_ready, vecs[i].exp_ready);
      n = 0;
      while (cfg_if.cfg_ready !== 1'b1 && n < 300) begin tick(); n++; end
      check("vec_drain", cfg_if.cfg_ready, 1);
      tick();
    end

    // Half bridge, P=40 W=20 D=0.
    en = 1'b0;
    tick();
    offer(40, 20, 0);
    tick();
    mode = 1'b1;
    en   = 1'b1;
    wait_cs(10, "half_cs");
    na = 0; nb = 0; nlsb = 0;
    for (int k = 0; k < 80; k++) begin
      if (hs_a) na++;
      if (hs_b) nb++;
      if (ls_b) nlsb++;
      tick();
    end
    check("half_hs_a", na, 40);
    check("half_hs_b", nb, 0);
    check("half_ls_b", nlsb, 80);

    // en drop while hs_a is on, D=4.
    en = 1'b0;
    tick();
    offer(100, 40, 4);
    tick();
    mode = 1'b0;
    en   = 1'b1;
    wait_cs(10, "drop_cs");
    repeat (10) tick();
    check("drop_pre_hs", hs_a, 1);
    en = 1'b0;
    tick();
    check("drop_hs_off", hs_a, 0);
    check("drop_ls_dead", ls_a, 0);
    repeat (3) tick();
    check("drop_ls_still_dead", ls_a, 0);
    tick();
    check("drop_ls_on", ls_a, 1);
    en = 1'b1;
    tick();
    check("reen_cs", cycle_start, 1);

    // Async reset while leg A is in DEAD.
    repeat (10) tick();
    en = 1'b0;
    tick();
    tick();
    check("mid_dead_hs", hs_a, 0);
    check("mid_dead_ls", ls_a, 0);
    async_reset("rst_dead");

    // Randomized traffic.
    en = 1'b1;
    for (int k = 0; k < 9000; k++) begin
      int p;
      p = $urandom_range(2, 60);
      drive_cfg(p, $urandom_range(0, p / 2 + 2), $urandom_range(0, 15));
      cfg_if.cfg_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 1999) == 0) begin
        cfg_if.cfg_valid = 1'b0;
        async_reset("rand_rst");
      end else begin
        tick();
      end
    end
    cfg_if.cfg_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
